// File: rtl/ensemble_vote_accumulator_if.sv
// Handshake bundle between the ensemble members' final LUT layers and the
// vote accumulator. The input side carries one member's packed per-class
// codes. The output side carries the winning class and its summed score.
interface ensemble_vote_accumulator_if #(
    parameter int NUM_CLASSES = 5,
    parameter int CODE_BITS   = 2,
    parameter int NUM_MEMBERS = 4,
    parameter int CLS_BITS    = 3
);
    localparam int SUM_BITS = CODE_BITS + $clog2(NUM_MEMBERS);

    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_CLASSES*CODE_BITS-1:0]  in_codes;
    logic                              out_valid;
    logic                              out_ready;
    logic [CLS_BITS-1:0]               out_class;
    logic [SUM_BITS-1:0]               out_score;

    // Producer side: drives member vectors and accepts results
    modport master (
        output in_valid,
        output in_codes,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_class,
        input  out_score
    );

    // Accumulator side
    modport slave (
        input  in_valid,
        input  in_codes,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_class,
        output out_score
    );
endinterface

// File: rtl/ensemble_vote_accumulator.sv
// Ensemble vote accumulator.
// Sums the 2-bit per-class codes of NUM_MEMBERS ensemble members, then scans
// the class sums one per cycle to find the argmax. Ties go to the lower index.
// The winner is held on a valid/ready output until it is taken. Only one
// result is in flight at a time.
module ensemble_vote_accumulator #(
    parameter int NUM_CLASSES = 5,
    parameter int CODE_BITS   = 2,
    parameter int NUM_MEMBERS = 4,
    parameter int CLS_BITS    = 3
) (
    input logic                        clk,
    input logic                        rst_n,
    ensemble_vote_accumulator_if.slave bus
);

    localparam int SUM_BITS = CODE_BITS + $clog2(NUM_MEMBERS);
    localparam int CNT_BITS = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;
    localparam int IDX_BITS = $clog2(NUM_CLASSES + 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ARGMAX = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;

    logic                 in_ready_c;
    logic                 out_valid_c;
    logic                 in_fire;
    logic                 out_fire;

    logic [CNT_BITS-1:0]  member_cnt;
    logic                 first_member;
    logic                 last_member;

    logic [CODE_BITS-1:0] codes [NUM_CLASSES];
    logic [SUM_BITS-1:0]  sums  [NUM_CLASSES];

    logic [IDX_BITS-1:0]  scan_idx;
    logic                 scan_done;
    logic [SUM_BITS-1:0]  cand_sum;
    logic                 take_cand;
    logic [SUM_BITS-1:0]  best_score;
    logic [CLS_BITS-1:0]  best_class;

    logic [CLS_BITS-1:0]  out_class_q;
    logic [SUM_BITS-1:0]  out_score_q;

    assign first_member = (member_cnt == '0);
    assign last_member  = (member_cnt == CNT_BITS'(NUM_MEMBERS - 1));
    assign scan_done    = (scan_idx == IDX_BITS'(NUM_CLASSES));

    assign in_fire  = bus.in_valid & in_ready_c;
    assign out_fire = out_valid_c & bus.out_ready;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;

    // Update the state register. Reset discards any partial ensemble or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Compute the next state and the handshake flags, which depend only on the state.
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_member) begin
                    next_state = ARGMAX;
                end
            end
            ARGMAX: begin
                if (scan_done) begin
                    next_state = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    // Unpack the incoming vector into one code per class.
    always_comb begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
            codes[i] = bus.in_codes[i*CODE_BITS +: CODE_BITS];
        end
    end

    // Count accepted members. Wrap to zero on the member that completes the ensemble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            member_cnt <= '0;
        end else if (in_fire) begin
            if (last_member) begin
                member_cnt <= '0;
            end else begin
                member_cnt <= member_cnt + CNT_BITS'(1);
            end
        end
    end

    // Accumulate per-class sums. The first member loads, later members add, and the sums clear once the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                sums[i] <= '0;
            end
        end else if (in_fire) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (first_member) begin
                    sums[i] <= SUM_BITS'(codes[i]);
                end else begin
                    sums[i] <= sums[i] + SUM_BITS'(codes[i]);
                end
            end
        end else if (out_fire) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                sums[i] <= '0;
            end
        end
    end

    // Select the sum of the class under scan. A strict compare keeps the lowest index on ties.
    always_comb begin
        cand_sum = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx == IDX_BITS'(k)) begin
                cand_sum = sums[k];
            end
        end
        take_cand = (scan_idx == '0) || (cand_sum > best_score);
    end

    // Scan one class per cycle. The extra cycle at scan_done hands over to the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx   <= '0;
            best_score <= '0;
            best_class <= '0;
        end else if (state == ARGMAX) begin
            if (scan_done) begin
                scan_idx <= '0;
            end else begin
                if (take_cand) begin
                    best_score <= cand_sum;
                    best_class <= CLS_BITS'(scan_idx);
                end
                scan_idx <= scan_idx + IDX_BITS'(1);
            end
        end
    end

    // Capture the winner when entering OUTPUT. It then stays stable until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_class_q <= '0;
            out_score_q <= '0;
        end else if ((state == ARGMAX) && scan_done) begin
            out_class_q <= best_class;
            out_score_q <= best_score;
        end
    end

endmodule

// File: tb/tb_ensemble_vote_accumulator.sv
// Bench for ensemble_vote_accumulator. It uses directed and randomized ensembles.
// Each expected result is recomputed from the accepted vectors by plain
// summation and a strict-greater argmax.
module tb_ensemble_vote_accumulator;

    localparam int NUM_CLASSES = 5;
    localparam int CODE_BITS   = 2;
    localparam int NUM_MEMBERS = 4;
    localparam int CLS_BITS    = 3;
    localparam int VEC_BITS    = NUM_CLASSES * CODE_BITS;
    localparam int LATENCY     = NUM_CLASSES + 1;

    typedef logic [VEC_BITS-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t acc_q[$];

    ensemble_vote_accumulator_if #(
        .NUM_CLASSES (NUM_CLASSES),
        .CODE_BITS   (CODE_BITS),
        .NUM_MEMBERS (NUM_MEMBERS),
        .CLS_BITS    (CLS_BITS)
    ) bus ();

    ensemble_vote_accumulator #(
        .NUM_CLASSES (NUM_CLASSES),
        .CODE_BITS   (CODE_BITS),
        .NUM_MEMBERS (NUM_MEMBERS),
        .CLS_BITS    (CLS_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t make_vec(input int c0, input int c1, input int c2, input int c3, input int c4);
        int   c [NUM_CLASSES];
        vec_t v;
        c = '{c0, c1, c2, c3, c4};
        v = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            v[i*CODE_BITS +: CODE_BITS] = c[i][CODE_BITS-1:0];
        end
        return v;
    endfunction

    // Reference: add up every accepted member's codes, then take the first class with the largest total
    task automatic model_result(output int cls, output int score);
        int   sums [NUM_CLASSES];
        vec_t v;
        for (int i = 0; i < NUM_CLASSES; i++) sums[i] = 0;
        foreach (acc_q[m]) begin
            v = acc_q[m];
            for (int i = 0; i < NUM_CLASSES; i++) begin
                sums[i] += int'(v[i*CODE_BITS +: CODE_BITS]);
            end
        end
        cls   = 0;
        score = sums[0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (sums[i] > score) begin
                cls   = i;
                score = sums[i];
            end
        end
    endtask

    task automatic applyStimulus(input vec_t vec, input bit valid, output bit accepted);
        bus.in_codes = vec;
        bus.in_valid = valid;
        accepted = valid && (bus.in_ready === 1'b1);
        step();
        if (accepted) acc_q.push_back(vec);
    endtask

    task automatic feed_member(input vec_t vec, input string tag);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            applyStimulus(vec, 1'b1, acc);
        end
        if (!acc) checkOutput({tag, "_accept_timeout"}, 0, 1);
    endtask

    // Call right after the last accept. Checks latency, the result, hold stability under backpressure, and the drop after transfer.
    task automatic wait_result(input string tag, input int hold);
        int exp_cls;
        int exp_score;
        int lat;
        model_result(exp_cls, exp_score);
        bus.out_ready = (hold == 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 4 * LATENCY) begin
            step();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, LATENCY);
        checkOutput({tag, "_class"}, 32'(bus.out_class), exp_cls);
        checkOutput({tag, "_score"}, 32'(bus.out_score), exp_score);
        for (int h = 0; h < hold; h++) begin
            step();
            checkOutput({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            checkOutput({tag, "_hold_class"}, 32'(bus.out_class), exp_cls);
            checkOutput({tag, "_hold_score"}, 32'(bus.out_score), exp_score);
            checkOutput({tag, "_hold_in_ready"}, 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        checkOutput({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        checkOutput({tag, "_in_ready_after"}, 32'(bus.in_ready), 1);
        acc_q.delete();
    endtask

    task automatic feed_ensemble(input vec_t vecs [NUM_MEMBERS], input string tag);
        for (int m = 0; m < NUM_MEMBERS; m++) feed_member(vecs[m], tag);
        bus.in_valid = 1'b0;
    endtask

    // Directed sequence followed by randomized ensembles
    initial begin
        vec_t vecs [NUM_MEMBERS];
        vec_t v;
        bit   acc;
        int   lat;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_codes  = '0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_codes = '1;
        step();
        step();
        checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset_out_class", 32'(bus.out_class), 0);
        checkOutput("reset_out_score", 32'(bus.out_score), 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Basic argmax: sums {4,8,12,0,4}
        for (int m = 0; m < NUM_MEMBERS; m++) vecs[m] = make_vec(1, 2, 3, 0, 1);
        feed_ensemble(vecs, "basic");
        wait_result("basic", 0);

        // Tie across all classes goes to class 0
        for (int m = 0; m < NUM_MEMBERS; m++) vecs[m] = make_vec(2, 2, 2, 2, 2);
        feed_ensemble(vecs, "tie");
        wait_result("tie", 0);

        // Last class wins at the maximum possible sum
        for (int m = 0; m < NUM_MEMBERS; m++) vecs[m] = make_vec(0, 0, 0, 0, 3);
        feed_ensemble(vecs, "lastidx");
        wait_result("lastidx", 0);

        // Backpressure with a new vector waiting, which must become member 0 afterwards
        for (int m = 0; m < NUM_MEMBERS; m++) vecs[m] = make_vec(1, 2, 3, 0, 1);
        feed_ensemble(vecs, "bp");
        bus.in_codes = make_vec(0, 0, 3, 0, 0);
        bus.in_valid = 1'b1;
        wait_result("bp", 10);
        applyStimulus(make_vec(0, 0, 3, 0, 0), 1'b1, acc);
        checkOutput("bp_member0_accept", 32'(acc), 1);
        for (int m = 1; m < NUM_MEMBERS; m++) feed_member(make_vec(0, 0, 0, 1, 0), "bp2");
        bus.in_valid = 1'b0;
        wait_result("bp2", 0);

        // Bubbles between transfers
        v = make_vec(1, 2, 3, 0, 1);
        applyStimulus(v, 1'b1, acc);
        applyStimulus(v, 1'b0, acc);
        applyStimulus(v, 1'b0, acc);
        applyStimulus(v, 1'b1, acc);
        applyStimulus(v, 1'b0, acc);
        applyStimulus(v, 1'b1, acc);
        checkOutput("bubble_count_in_ready", 32'(bus.in_ready), 1);
        applyStimulus(v, 1'b1, acc);
        bus.in_valid = 1'b0;
        checkOutput("bubble_members", acc_q.size(), NUM_MEMBERS);
        wait_result("bubble", 0);

        // Reset in the middle of accumulation discards the partial ensemble
        feed_member(make_vec(3, 3, 3, 3, 3), "mid");
        feed_member(make_vec(3, 3, 3, 3, 3), "mid");
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 1);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 0);
        #1 rst_n = 1'b1;
        bus.in_valid = 1'b0;
        acc_q.delete();
        for (int m = 0; m < NUM_MEMBERS; m++) vecs[m] = make_vec(0, 1, 0, 0, 0);
        feed_ensemble(vecs, "postrst");
        wait_result("postrst", 0);

        // Reset while a result is pending
        for (int m = 0; m < NUM_MEMBERS; m++) vecs[m] = make_vec(0, 3, 1, 2, 0);
        feed_ensemble(vecs, "pend");
        bus.out_ready = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 4 * LATENCY) begin
            step();
            lat++;
        end
        checkOutput("pend_valid_before_reset", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("pendrst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("pendrst_out_class", 32'(bus.out_class), 0);
        checkOutput("pendrst_out_score", 32'(bus.out_score), 0);
        checkOutput("pendrst_in_ready", 32'(bus.in_ready), 1);
        #1 rst_n = 1'b1;
        acc_q.delete();
        bus.out_ready = 1'b1;

        // Randomized ensembles with random bubbles and backpressure
        for (int r = 0; r < 12; r++) begin
            for (int m = 0; m < NUM_MEMBERS; m++) begin
                v = vec_t'($urandom);
                while ($urandom_range(0, 3) == 0) applyStimulus(v, 1'b0, acc);
                feed_member(v, "rand");
            end
            bus.in_valid = 1'b0;
            wait_result("rand", int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
